// File: rtl/btb_pkg.sv
// Shared constants and types for the branch target buffer.
package btb_pkg;

  localparam int CTR_W = 2;

  typedef logic [CTR_W-1:0] ctr_t;

  // Two-bit direction counter states; bit 1 is the taken prediction.
  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  localparam ctr_t CTR_RST   = SNT;
  localparam ctr_t CTR_ALLOC = WT;

  // Sequential fetch stride in bytes.
  localparam int PC_INC = 4;

endpackage

// File: rtl/btb_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
module btb_sat_counter
  import btb_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  // Step toward the resolved direction, saturating at ST and SNT.
  always_comb begin
    ctr_next = ctr;
    unique case (ctr)
      SNT:     ctr_next = taken ? WNT : SNT;
      WNT:     ctr_next = taken ? WT  : SNT;
      WT:      ctr_next = taken ? ST  : WNT;
      ST:      ctr_next = taken ? ST  : WT;
      default: ctr_next = ctr;
    endcase
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer: registered lookup, same-edge update,
// synchronous flush of the valid vector.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 8,
  parameter int PC_WIDTH   = 64
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                flush,
  input  logic                lookup_en,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                pred_valid,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target,
  input  logic                update_en,
  input  logic [PC_WIDTH-1:0] update_pc,
  input  logic                update_taken,
  input  logic [PC_WIDTH-1:0] update_target
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LO  = INDEX_BITS + 2;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];
  ctr_t                ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0]   lk_tag, up_tag;
  logic                  lk_hit, lk_taken, up_hit;
  logic [PC_WIDTH-1:0]   lk_target;
  ctr_t                  up_ctr_next;

  logic                vld_p1;
  logic                hit_p1;
  logic                taken_p1;
  logic [PC_WIDTH-1:0] target_p1;

  // Alignment bits and PC bits above the tag never take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], lookup_pc[PC_WIDTH-1:TAG_HI+1],
                            update_pc[1:0], update_pc[PC_WIDTH-1:TAG_HI+1]};

  assign lk_idx = lookup_pc[TAG_LO-1:2];
  assign lk_tag = lookup_pc[TAG_HI:TAG_LO];
  assign up_idx = update_pc[TAG_LO-1:2];
  assign up_tag = update_pc[TAG_HI:TAG_LO];

  // Lookup reads the pre-update state, giving read-before-write on collisions.
  always_comb begin
    lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken  = lk_hit && ctr_q[lk_idx][1];
    lk_target = lk_taken ? target_q[lk_idx] : lookup_pc + PC_WIDTH'(PC_INC);
    up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  end

  btb_sat_counter u_sat_counter (
    .ctr      (ctr_q[up_idx]),
    .taken    (update_taken),
    .ctr_next (up_ctr_next)
  );

  // ---- stage p1: registered prediction, held while no lookup is issued ----
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_p1    <= 1'b0;
      hit_p1    <= 1'b0;
      taken_p1  <= 1'b0;
      target_p1 <= '0;
    end else begin
      vld_p1 <= lookup_en;
      if (lookup_en) begin
        hit_p1    <= lk_hit;
        taken_p1  <= lk_taken;
        target_p1 <= lk_target;
      end
    end
  end

  assign pred_valid  = vld_p1;
  assign pred_hit    = hit_p1;
  assign pred_taken  = taken_p1;
  assign pred_target = target_p1;

  // Valid vector: cleared by reset or flush, set on a taken-miss allocation.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (update_en && !up_hit && update_taken) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // Entry payload: train counter/target on a hit, allocate on a taken miss.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RST;
      end
    end else if (update_en && !flush) begin
      if (up_hit) begin
        ctr_q[up_idx] <= up_ctr_next;
        if (update_taken) target_q[up_idx] <= update_target;
      end else if (update_taken) begin
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= update_target;
        ctr_q[up_idx]    <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed and randomized bench for btb_predictor against a table-level model.
module tb_btb_predictor;

  localparam int IB = 5;
  localparam int TB = 8;
  localparam int PW = 64;
  localparam int N  = 1 << IB;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          flush;
  logic          lookup_en;
  logic [PW-1:0] lookup_pc;
  logic          pred_valid;
  logic          pred_hit;
  logic          pred_taken;
  logic [PW-1:0] pred_target;
  logic          update_en;
  logic [PW-1:0] update_pc;
  logic          update_taken;
  logic [PW-1:0] update_target;

  btb_predictor #(.INDEX_BITS(IB), .TAG_BITS(TB), .PC_WIDTH(PW)) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .flush         (flush),
    .lookup_en     (lookup_en),
    .lookup_pc     (lookup_pc),
    .pred_valid    (pred_valid),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .update_en     (update_en),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target)
  );

  always #5 clk = ~clk;

  // Reference table: one record per index, counter kept as an integer 0..3.
  bit            m_valid  [N];
  int unsigned   m_tag    [N];
  logic [PW-1:0] m_target [N];
  int            m_ctr    [N];

  logic          e_valid, e_hit, e_taken;
  logic [PW-1:0] e_target;

  int total  = 0;
  int passed = 0;

  function automatic int idx_of(input logic [PW-1:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic int unsigned tag_of(input logic [PW-1:0] pc);
    return int'((pc >> (IB + 2)) % (1 << TB));
  endfunction

  function automatic logic [PW-1:0] mk_pc(input int tag, input int idx);
    logic [PW-1:0] r;
    r = {$urandom, $urandom};
    r[IB+TB+1:2] = (IB+TB)'(tag * N + idx);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 0;
      m_target[i] = '0;
      m_ctr[i]    = 0;
    end
    e_valid  = 1'b0;
    e_hit    = 1'b0;
    e_taken  = 1'b0;
    e_target = '0;
  endtask

  // One rising edge of the reference: predict from old state, then train.
  task automatic model_edge();
    int  li, ui;
    bit  uhit;
    e_valid = lookup_en;
    if (lookup_en) begin
      li       = idx_of(lookup_pc);
      e_hit    = m_valid[li] && (m_tag[li] == tag_of(lookup_pc));
      e_taken  = e_hit && (m_ctr[li] >= 2);
      e_target = e_taken ? m_target[li] : lookup_pc + 64'd4;
    end
    if (flush) begin
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    end else if (update_en) begin
      ui   = idx_of(update_pc);
      uhit = m_valid[ui] && (m_tag[ui] == tag_of(update_pc));
      if (uhit) begin
        if (update_taken) begin
          m_ctr[ui]    = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
          m_target[ui] = update_target;
        end else begin
          m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
        end
      end else if (update_taken) begin
        m_valid[ui]  = 1'b1;
        m_tag[ui]    = tag_of(update_pc);
        m_target[ui] = update_target;
        m_ctr[ui]    = 2;
      end
    end
  endtask

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string step);
    check({step, ".pred_valid"},  PW'(pred_valid), PW'(e_valid));
    check({step, ".pred_hit"},    PW'(pred_hit),   PW'(e_hit));
    check({step, ".pred_taken"},  PW'(pred_taken), PW'(e_taken));
    check({step, ".pred_target"}, pred_target,     e_target);
  endtask

  task automatic cyc(input string step, input bit lk, input logic [PW-1:0] lpc,
                     input bit up, input logic [PW-1:0] upc, input bit utk,
                     input logic [PW-1:0] utgt, input bit fl);
    lookup_en     = lk;
    lookup_pc     = lpc;
    update_en     = up;
    update_pc     = upc;
    update_taken  = utk;
    update_target = utgt;
    flush         = fl;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(step);
  endtask

  task automatic look(input string step, input logic [PW-1:0] pc);
    cyc(step, 1'b1, pc, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic upd(input string step, input logic [PW-1:0] pc, input bit tk,
                     input logic [PW-1:0] tgt);
    cyc(step, 1'b0, '0, 1'b1, pc, tk, tgt, 1'b0);
  endtask

  initial begin
    logic [PW-1:0] pcs [4];
    arst_n        = 1'b0;
    flush         = 1'b0;
    lookup_en     = 1'b0;
    lookup_pc     = '0;
    update_en     = 1'b0;
    update_pc     = '0;
    update_taken  = 1'b0;
    update_target = '0;
    model_reset();
    #12;
    check_outputs("reset");
    arst_n = 1'b1;
    #1;

    // First lookup after reset misses and predicts fall-through.
    look("cold", 64'h1000);

    // Allocate then hit with weak-taken counter.
    upd("alloc", 64'h1000, 1'b1, 64'h2000);
    look("hit_taken", 64'h1000);

    // Train down to strong-not-taken, saturating there.
    for (int k = 0; k < 4; k++) upd("nt_train", 64'h1000, 1'b0, 64'h0);
    look("hit_nt", 64'h1000);
    upd("tk_once", 64'h1000, 1'b1, 64'h2400);
    look("still_nt", 64'h1000);

    // Alias at the same index replaces the entry.
    upd("re_tk", 64'h1000, 1'b1, 64'h2000);
    upd("alias", 64'h1000 + (64'd1 << (IB + 2)), 1'b1, 64'h3000);
    look("alias_old", 64'h1000);
    look("alias_new", 64'h1000 + (64'd1 << (IB + 2)));

    // Same-cycle lookup and update on an empty table: read-before-write.
    cyc("flush0", 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    cyc("rbw", 1'b1, 64'h1000, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0);
    look("rbw_after", 64'h1000);

    // Flush wins over a simultaneous update.
    cyc("flush_upd", 1'b0, '0, 1'b1, 64'h1100, 1'b1, 64'h5000, 1'b1);
    look("post_flush_a", 64'h1000);
    look("post_flush_b", 64'h1100);

    // Fall-through wraps modulo 2**PW.
    look("wrap", 64'hFFFF_FFFF_FFFF_FFFC);

    // Randomized traffic over a few tags per index to provoke aliasing.
    for (int k = 0; k < 400; k++) begin
      cyc("rand",
          1'($urandom_range(0, 3) != 0), mk_pc($urandom_range(0, 2), $urandom_range(0, N-1)),
          1'($urandom_range(0, 1)), mk_pc($urandom_range(0, 2), $urandom_range(0, N-1)),
          1'($urandom_range(0, 2) != 0), {$urandom, $urandom},
          1'($urandom_range(0, 39) == 0));
    end

    // Populate entries, then assert reset mid-update.
    for (int k = 0; k < 4; k++) begin
      pcs[k] = mk_pc(k + 1, k * 5);
      upd("pop", pcs[k], 1'b1, 64'h8000 + 64'(k * 16));
    end
    look("pop_hit", pcs[2]);
    lookup_en     = 1'b1;
    lookup_pc     = pcs[0];
    update_en     = 1'b1;
    update_pc     = pcs[1];
    update_taken  = 1'b1;
    update_target = 64'h9999;
    @(posedge clk);
    model_edge();
    #2;
    arst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("arst_mid");
    @(posedge clk);
    #1;
    check_outputs("arst_held");
    lookup_en = 1'b0;
    update_en = 1'b0;
    #2;
    arst_n = 1'b1;
    for (int k = 0; k < 4; k++) look("post_arst", pcs[k]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Parametrised branch target buffer with per-entry 2-bit saturating direction counters, tag match and stored targets, sitting beside the fetch-stage PC register. Fetch issues a lookup each cycle and receives a registered hit/taken/target prediction one cycle later. The execute stage writes back resolved branch outcome and target. A synchronous flush clears all entries.

## Interface
- `INDEX_BITS`, 5: log2 of entry count (2**INDEX_BITS entries)
- `TAG_BITS`, 8: stored tag width
- `PC_WIDTH`, 64: PC and target width
- `clk` in 1: single clock, all state on rising edge
- `arst_n` in 1: asynchronous active-low reset
- `flush` in 1: synchronous invalidate of all entries
- `lookup_en` in 1: lookup request this cycle
- `lookup_pc` in PC_WIDTH: fetch PC
- `pred_valid` out 1: registered copy of lookup_en
- `pred_hit` out 1: lookup found valid entry with matching tag
- `pred_taken` out 1: predicted taken (hit and counter[1])
- `pred_target` out PC_WIDTH: predicted next PC
- `update_en` in 1: resolved branch write-back
- `update_pc` in PC_WIDTH: PC of resolved branch
- `update_taken` in 1: actual direction
- `update_target` in PC_WIDTH: actual target

## Operation
- PCs are 4-byte aligned; bits [1:0] ignored.
- index = pc[INDEX_BITS+1:2]; tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
- Entry = {valid, tag, target, ctr[1:0]}. Counter states: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Lookup: hit = valid & tag match. pred_taken = hit & ctr[1]. pred_target = pred_taken ? target : lookup_pc+4 (modulo 2**PC_WIDTH). When lookup_en=0, pred_valid=0 and other outputs hold previous values.
- Update, entry hit: ctr saturating +1 if taken, −1 if not taken (11 stays 11, 00 stays 00); target overwritten with update_target only when taken.
- Update, miss and taken: allocate/replace (direct-mapped): valid=1, tag written, target=update_target, ctr=10.
- Update, miss and not taken: no state change.
- flush: all valid bits cleared next edge; counters/targets untouched. flush and update_en same cycle: flush wins, update dropped.

## Timing
- Lookup latency 1 cycle: pred_* registered on the edge after lookup_en.
- Update takes effect on the edge it is presented; visible to lookups issued the following cycle.
- Same-cycle lookup and update to the same index: read-before-write, lookup returns pre-update entry.
- Reset (arst_n low, any time, including mid-update): all valid=0, all ctr=00, targets 0, pred_valid=0, pred_hit=0, pred_taken=0, pred_target=0. Pending lookup/update discarded; first lookup after release returns miss.
- No back-pressure; one lookup and one update accepted every cycle.

## Structure
- Package `btb_pkg`: counter state constants (SNT, WNT, WT, ST), counter width, reset/allocate counter values, PC increment (4).
- Sub-module `btb_sat_counter`: combinational 2-bit next-state function (ctr, taken → next ctr); instantiated once on the update path.
- Storage: separate valid vector (flush/reset) and arrays for tag, target, counter.

## Test plan
- Reset then lookup_pc=0x1000 → next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0x1004.
- Update pc=0x1000 taken target=0x2000, then lookup 0x1000 → hit=1, taken=1 (ctr 10), target=0x2000.
- Four not-taken updates on 0x1000 from ctr=10 → ctr 01,00,00,00; lookup → hit=1, taken=0, target=0x1004; one taken update → ctr 01, still not taken.
- Alias: allocate 0x1000, then taken update 0x1000+(1<<(INDEX_BITS+2)) target 0x3000 → lookup 0x1000 misses, aliasing PC hits with target 0x3000.
- Same-cycle lookup+update 0x1000 on empty table → lookup misses; next lookup hits. flush with simultaneous update → all subsequent lookups miss.
- Assert arst_n low mid-stream with several valid entries → all outputs 0 immediately; post-release lookups all miss.
